// File: rtl/conversor_bcd_if.sv
// Handshake and data bundle between the multiplier-side requester and the
// binary-to-BCD converter.
//   start/Result/OFLOW : conversion request and captured payload (master -> slave)
//   busy/done          : conversion status (slave -> master)
//   bcd/blank/oflow_q  : displayed value, leading-zero mask, captured overflow
interface conversor_bcd_if #(
  parameter int BIT    = 4,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [2*BIT-1:0]      Result;
  logic                  OFLOW;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
  logic                  oflow_q;

  modport master (output start, Result, OFLOW,
                  input  busy, done, bcd, blank, oflow_q);
  modport slave  (input  start, Result, OFLOW,
                  output busy, done, bcd, blank, oflow_q);
endinterface

// File: rtl/conversor_bcd.sv
// Sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
// Captures a 2*BIT-bit product plus overflow flag on start, runs 2*BIT
// shift steps, then publishes packed BCD digits, a leading-zero blank mask
// and the captured overflow flag with a one-cycle done pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any conversion
//   bus  : conversor_bcd_if.slave (start/Result/OFLOW in; busy/done/bcd/blank/oflow_q out)

// Per-digit add-3 adjust: a digit of 5..9 becomes 8..12 so that the
// following left shift carries correctly into the next decade.
module conversor_bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module conversor_bcd #(
  parameter int BIT    = 4,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst,
  conversor_bcd_if.slave  bus
);
  localparam int NB = 2*BIT;
  localparam int CW = $clog2(NB+1);

  generate
    if (10**DIGITS < 2**NB) begin : g_chk
      $error("conversor_bcd: DIGITS too small for 2*BIT-bit product");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [NB-1:0]           bin;
  logic [DIGITS-1:0][3:0]  scr;
  logic [CW-1:0]           cnt;
  logic                    ofl_cap;

  logic [DIGITS-1:0][3:0]  adj;
  logic [DIGITS-1:0][3:0]  scr_nxt;
  logic [NB-1:0]           bin_nxt;
  logic [DIGITS-1:0]       mask_nxt;

  // Reset mask: every digit except digit 0 blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      conversor_bcd_add3 u_add3 (.d(scr[g]), .q(adj[g]));
    end
  endgenerate

  // One double-dabble step: adjusted scratch and binary shift left as one
  // register, binary MSB entering scratch bit 0.
  always_comb begin
    scr_nxt = {adj[DIGITS-1:0], bin[NB-1]} >> 0;
    scr_nxt = {adj, bin[NB-1]} & {(4*DIGITS){1'b1}};
    bin_nxt = {bin[NB-2:0], 1'b0};
  end

  // Leading-zero mask over the value being published; digit 0 always shown.
  always_comb begin
    logic allz;
    mask_nxt = '0;
    allz     = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      allz        = allz & (scr_nxt[i] == 4'd0);
      mask_nxt[i] = allz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bin         <= '0;
      scr         <= '0;
      cnt         <= '0;
      ofl_cap     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd     <= '0;
      bus.blank   <= BLANK_RST;
      bus.oflow_q <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin      <= bus.Result;
            scr      <= '0;
            ofl_cap  <= bus.OFLOW;
            cnt      <= CW'(NB);
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= scr_nxt;
          bin <= bin_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.bcd     <= scr_nxt;
            bus.blank   <= mask_nxt;
            bus.oflow_q <= ofl_cap;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd (BIT=4, DIGITS=3): table vectors,
// hand-written multi-cycle sequences and randomized conversions checked
// against a decimal-arithmetic reference model.
module tb_conversor_bcd;
  localparam int BIT    = 4;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conversor_bcd_if #(.BIT(BIT), .DIGITS(DIGITS)) bus ();
  conversor_bcd #(.BIT(BIT), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  result;
    logic        oflow;
    logic [11:0] exp_bcd;
    logic [2:0]  exp_blank;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decimal digits by division, mask by magnitude.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10**i)) % 10);
    return r;
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
    logic [2:0] m = '0;
    for (int i = 1; i < DIGITS; i++) m[i] = ((v / (10**i)) == 0);
    return m;
  endfunction

  task automatic do_conv(input string name, input logic [7:0] r, input logic o,
                         input logic [11:0] eb, input logic [2:0] ebl);
    logic [11:0] prev;
    int lat, bc;
    bit stable;
    @(negedge clk);
    bus.start = 1'b1; bus.Result = r; bus.OFLOW = o;
    prev = bus.bcd; lat = 0; bc = 0; stable = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0; bus.Result = 8'($urandom); bus.OFLOW = 1'($urandom);
      end
      if (bus.done) begin lat = k; break; end
      if (bus.busy) bc++;
      if (bus.bcd !== prev) stable = 0;
    end
    chk({name, " latency"}, lat, 9);
    chk({name, " busy_cycles"}, bc, 8);
    chk({name, " busy_in_done"}, bus.busy, 0);
    chk({name, " bcd"}, bus.bcd, eb);
    chk({name, " blank"}, bus.blank, ebl);
    chk({name, " oflow_q"}, bus.oflow_q, o);
    chk({name, " hold_during"}, stable, 1);
    @(negedge clk);
    chk({name, " done_1cyc"}, bus.done, 0);
    chk({name, " hold_after"}, bus.bcd, eb);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, " busy"}, bus.busy, 0);
    chk({name, " done"}, bus.done, 0);
    chk({name, " bcd"}, bus.bcd, 12'h000);
    chk({name, " blank"}, bus.blank, 3'b110);
    chk({name, " oflow_q"}, bus.oflow_q, 0);
  endtask

  vec_t vt[5];

  initial begin
    int nd, l1, l2;
    logic [7:0] rv;
    logic ov;
    vt[0] = '{8'd225, 1'b1, 12'h225, 3'b000};
    vt[1] = '{8'd0,   1'b0, 12'h000, 3'b110};
    vt[2] = '{8'd7,   1'b0, 12'h007, 3'b110};
    vt[3] = '{8'd42,  1'b0, 12'h042, 3'b100};
    vt[4] = '{8'd100, 1'b0, 12'h100, 3'b000};

    bus.start = 1'b0; bus.Result = '0; bus.OFLOW = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      do_conv($sformatf("vec%0d", i), vt[i].result, vt[i].oflow, vt[i].exp_bcd, vt[i].exp_blank);

    // start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.Result = 8'd42; bus.OFLOW = 1'b0;
    nd = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 3) begin bus.start = 1'b1; bus.Result = 8'd99; end
      if (k == 4) bus.start = 1'b0;
      if (bus.done) nd++;
    end
    chk("ignore done_count", nd, 1);
    chk("ignore bcd", bus.bcd, 12'h042);

    // back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.Result = 8'd15;
    l1 = 0; l2 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (l1 == 0) begin
          l1 = k;
          chk("b2b first bcd", bus.bcd, 12'h015);
          bus.Result = 8'd200;
        end else begin
          l2 = k;
          chk("b2b second bcd", bus.bcd, 12'h200);
          chk("b2b second blank", bus.blank, 3'b000);
          bus.start = 1'b0;
          break;
        end
      end
    end
    chk("b2b first latency", l1, 9);
    chk("b2b spacing", l2 - l1, 9);
    @(negedge clk);
    chk("b2b idle after", bus.busy, 0);

    // reset mid-conversion
    do_conv("pre_rst", 8'd225, 1'b1, 12'h225, 3'b000);
    @(negedge clk);
    bus.start = 1'b1; bus.Result = 8'd17; bus.OFLOW = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    nd = 0;
    repeat (12) begin @(negedge clk); if (bus.done) nd++; end
    chk("midrst no_done", nd, 0);
    do_conv("post_rst", 8'd17, 1'b0, 12'h017, 3'b100);

    // randomized against the reference model
    for (int i = 0; i < 30; i++) begin
      rv = 8'($urandom_range(0, 255));
      ov = 1'($urandom);
      do_conv($sformatf("rnd%0d_%0d", i, rv), rv, ov, ref_bcd(int'(rv)), ref_blank(int'(rv)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
